// File: rtl/shift32_sequencer.sv
// Sequences a 32-bit logical right shift through one shared 16-bit right shifter,
// using up to three passes per request; one request in flight at a time.
module shift32_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_amt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] sh_in,
    output logic [3:0]  sh_offset,
    input  logic [15:0] sh_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned OFF_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS_HI  = 3'd1,
        PASS_LO  = 3'd2,
        PASS_X   = 3'd3,
        PASS_L16 = 3'd4,
        DONE     = 3'd5
    } state_t;

    function automatic logic [HALF_W-1:0] bitrev16(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] r;
        for (int i = 0; i < int'(HALF_W); i++) begin
            r[i] = x[int'(HALF_W) - 1 - i];
        end
        return r;
    endfunction

    state_t              state, state_d;
    logic [HALF_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_valid_d, busy_d;
    logic [HALF_W-1:0]   sh_in_d;
    logic [OFF_W-1:0]    sh_offset_d;

    // req_ready is gated by rst so nothing is accepted while reset is asserted
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            amt_q     <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            sh_in     <= '0;
            sh_offset <= '0;
        end else begin
            state     <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            amt_q     <= amt_d;
            rsp_data  <= rsp_data_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
            sh_in     <= sh_in_d;
            sh_offset <= sh_offset_d;
        end
    end

    always_comb begin
        state_d     = state;
        hi_d        = hi_q;
        lo_d        = lo_q;
        amt_d       = amt_q;
        rsp_data_d  = rsp_data;
        sh_in_d     = '0;
        sh_offset_d = '0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    hi_d  = req_data[DATA_W-1:HALF_W];
                    lo_d  = req_data[HALF_W-1:0];
                    amt_d = req_amt;
                    if (req_amt == '0) begin
                        rsp_data_d = req_data;
                        state_d    = DONE;
                    end else if (req_amt[AMT_W-1]) begin
                        rsp_data_d = '0;
                        state_d    = PASS_L16;
                    end else begin
                        rsp_data_d = '0;
                        state_d    = PASS_HI;
                    end
                end
            end
            PASS_HI: begin
                rsp_data_d[DATA_W-1:HALF_W] = sh_out;
                state_d = PASS_LO;
            end
            PASS_LO: begin
                rsp_data_d[HALF_W-1:0] = sh_out;
                state_d = PASS_X;
            end
            // Bits of hi that spill into the low half: reverse, right shift, reverse back.
            PASS_X: begin
                rsp_data_d[HALF_W-1:0] = rsp_data[HALF_W-1:0] | bitrev16(sh_out);
                state_d = DONE;
            end
            PASS_L16: begin
                rsp_data_d = {HALF_W'(0), sh_out};
                state_d    = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shifter drive is registered from the upcoming state so it lines up with that pass.
        case (state_d)
            PASS_HI: begin
                sh_in_d     = hi_d;
                sh_offset_d = amt_d[OFF_W-1:0];
            end
            PASS_LO: begin
                sh_in_d     = lo_d;
                sh_offset_d = amt_d[OFF_W-1:0];
            end
            PASS_X: begin
                sh_in_d     = bitrev16(hi_d);
                sh_offset_d = OFF_W'(AMT_W'(HALF_W) - amt_d);
            end
            PASS_L16: begin
                sh_in_d     = hi_d;
                sh_offset_d = amt_d[OFF_W-1:0];
            end
            default: begin
                sh_in_d     = '0;
                sh_offset_d = '0;
            end
        endcase

        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: doc/shift32_sequencer.md
# shift32_sequencer

Sequences a 32-bit logical right shift (amount 0–31) through one shared 16-bit combinational right shifter, using up to three passes per request. Sits between a requester (valid/ready) and the 16-bit shifter instance, driving its data and offset inputs and capturing its output. One request is in flight at a time.

## Interface
- Parameters: none. Widths are fixed: 32-bit operand, 5-bit amount, 16-bit shifter port.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE and when rst is low.
- req_data  in  32  operand; [31:16] is hi, [15:0] is lo.
- req_amt  in  5  shift amount, 0–31.
- rsp_valid  out  1  result available; registered.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result, equal to req_data >> req_amt (zero-fill); registered.
- busy  out  1  high when state is not IDLE.
- sh_in  out  16  data to the shared shifter; 0 outside pass states.
- sh_offset  out  4  offset to the shared shifter; 0 outside pass states.
- sh_out  in  16  shifter result; combinational, valid in the same cycle as sh_in/sh_offset.

## Operation
- States: IDLE, PASS_HI, PASS_LO, PASS_X, PASS_L16, DONE.
- Accept: req_valid and req_ready in IDLE. Latch hi, lo and amt into internal registers, then clear rsp_data to 0.
  - amt == 0: go to DONE with rsp_data = req_data.
  - amt >= 16: go to PASS_L16.
  - amt 1–15: go to PASS_HI.
- PASS_HI: sh_in = hi, sh_offset = amt. rsp_data[31:16] <= sh_out. Next state PASS_LO.
- PASS_LO: sh_in = lo, sh_offset = amt. rsp_data[15:0] <= sh_out. Next state PASS_X.
- PASS_X: sh_in = bitrev(hi), sh_offset = 16 − amt (range 1–15). rsp_data[15:0] <= rsp_data[15:0] | bitrev(sh_out). This equals the low 16 bits of hi << (16 − amt). Next state DONE.
- PASS_L16: sh_in = hi, sh_offset = amt − 16. rsp_data <= {16'h0, sh_out}. Next state DONE.
- DONE: rsp_valid = 1. rsp_data holds stable until rsp_ready; then go to IDLE.
- req_ready is 0 in every state except IDLE. req_valid outside IDLE is ignored; no queuing.
- No same-cycle response-to-request overlap: a new accept needs IDLE, which comes the cycle after the rsp handshake.
- The shifter is only driven in pass states. The idle drive of 0/0 is a requirement, because the shifter is shared.

## Timing
- Reset (rst high at an edge) overrides all other inputs. After reset:
  - state IDLE
  - rsp_valid 0, rsp_data 0, busy 0
  - sh_in 0, sh_offset 0
  - req_ready 0 while rst is high, 1 in the first cycle after rst is low.
- Reset mid-operation aborts the request. No rsp_valid is produced for it and internal latches are don't-care.
- Latency, counted from the accept edge (cycle 0) to the first cycle with rsp_valid high:
  - amt = 0: 1 cycle.
  - amt 16–31: 2 cycles.
  - amt 1–15: 4 cycles.
- Throughput: one request per (latency + 1) cycles at best, assuming rsp_ready is held high.
- rsp_valid, once high, stays high with rsp_data unchanged until the cycle rsp_ready is sampled high.
- busy rises the cycle after accept and falls the cycle after the rsp handshake.

## Test plan
- req_data 0x8000_0001, amt 1 -> rsp_data 0x4000_0000, rsp_valid at cycle 4; sh_offset sequence 1, 1, 15.
- req_data 0x1234_5678, amt 4 -> rsp_data 0x0123_4567. sh_in sequence 0x1234, 0x5678, bitrev(0x1234)=0x2C48. sh_offset 4, 4, 12.
- amt 0 with 0xDEAD_BEEF -> 0xDEAD_BEEF at cycle 1, shifter inputs stay 0. amt 16 with 0x1234_5678 -> 0x0000_1234 at cycle 2. amt 31 with 0x8000_0000 -> 0x0000_0001.
- Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_valid and rsp_data stable, req_ready 0. A competing req_valid is not accepted; it is accepted only the cycle after the handshake.
- rst pulsed one cycle while in PASS_LO (amt 7) -> next cycle IDLE, rsp_valid 0, rsp_data 0, busy 0, no response. The following request amt 8 of 0xFFFF_FFFF returns 0x00FF_FFFF.
- Random sweep: 1000 requests, all amt 0–31, random rsp_ready stalls. rsp_data matches req_data >> amt in order, with exact latency per amt class.
